// File: rtl/m_issue_ctrl.sv
// EX-stage initiator for the PCPI M-extension coprocessor. It decodes RV32M ops,
// issues them with latched operands, stalls the pipe and presents the result for writeback.
module m_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_instruction,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_busy,
    input  logic        pcpi_ready,
    output logic        stall_req,
    output logic        m_result_valid,
    output logic [31:0] m_result,
    output logic [4:0]  m_rd_addr,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             is_m_s;
    logic             issue_s;
    logic             timeout_hit_s;
    logic             pcpi_valid_r;
    logic [31:0]      pcpi_insn_r;
    logic [31:0]      pcpi_rs1_r;
    logic [31:0]      pcpi_rs2_r;
    logic [31:0]      m_result_r;
    logic             m_result_valid_r;
    logic             timeout_err_r;
    logic             stall_s;

    assign is_m_s        = (ex_instruction[6:0] == 7'b0110011) && (ex_instruction[31:25] == 7'b0000001);
    assign issue_s       = ex_valid && is_m_s && !flush;
    assign timeout_hit_s = (state_r == ST_WAIT) && (cnt_r == CNT_LAST);

    // Next-state decode; flush in WAIT outranks both ready and timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) next_state_s = ST_WAIT;
                else         next_state_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (flush)                            next_state_s = ST_DRAIN;
                else if (pcpi_ready || timeout_hit_s) next_state_s = ST_DONE;
                else                                  next_state_s = ST_WAIT;
            end
            ST_DONE: begin
                if (!ex_hold || flush) next_state_s = ST_IDLE;
                else                   next_state_s = ST_DONE;
            end
            ST_DRAIN: begin
                if (!pcpi_busy && !pcpi_ready) next_state_s = ST_IDLE;
                else                           next_state_s = ST_DRAIN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Stall is combinational so the detecting cycle already freezes the pipe.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE:  stall_s = issue_s;
            ST_WAIT:  stall_s = 1'b1;
            ST_DONE:  stall_s = 1'b0;
            ST_DRAIN: stall_s = issue_s;
            default:  stall_s = 1'b0;
        endcase
    end

    // FSM state, request latches, timeout counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            cnt_r            <= '0;
            pcpi_valid_r     <= 1'b0;
            pcpi_insn_r      <= 32'd0;
            pcpi_rs1_r       <= 32'd0;
            pcpi_rs2_r       <= 32'd0;
            m_result_r       <= 32'd0;
            m_result_valid_r <= 1'b0;
            timeout_err_r    <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            pcpi_valid_r     <= (next_state_s == ST_WAIT);
            m_result_valid_r <= (next_state_s == ST_DONE);
            timeout_err_r    <= timeout_hit_s && !flush && !pcpi_ready;
            if ((state_r == ST_IDLE) && issue_s) begin
                pcpi_insn_r <= ex_instruction;
                pcpi_rs1_r  <= ex_rs1;
                pcpi_rs2_r  <= ex_rs2;
                cnt_r       <= '0;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            // An abandoned operation reports zero rather than a stale value.
            if ((state_r == ST_WAIT) && !flush) begin
                if (pcpi_ready)         m_result_r <= pcpi_wr ? pcpi_rd : 32'd0;
                else if (timeout_hit_s) m_result_r <= 32'd0;
            end
        end
    end

    assign pcpi_valid     = pcpi_valid_r;
    assign pcpi_insn      = pcpi_insn_r;
    assign pcpi_rs1       = pcpi_rs1_r;
    assign pcpi_rs2       = pcpi_rs2_r;
    assign stall_req      = stall_s;
    assign m_result_valid = m_result_valid_r;
    assign m_result       = m_result_r;
    assign m_rd_addr      = pcpi_insn_r[11:7];
    assign timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Directed bench for m_issue_ctrl: decode table plus hand-written multi-cycle sequences.
// A second instance with a short timeout covers the silent-responder case.
module tb_m_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        b_ex_valid = 1'b0;
    logic [31:0] ex_instruction = 32'd0;
    logic [31:0] ex_rs1 = 32'd0;
    logic [31:0] ex_rs2 = 32'd0;
    logic        ex_hold = 1'b0;
    logic        flush = 1'b0;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = 32'd0;
    logic        pcpi_busy = 1'b0;
    logic        pcpi_ready = 1'b0;

    logic        pcpi_valid, stall_req, m_result_valid, timeout_err;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, m_result;
    logic [4:0]  m_rd_addr;

    logic        b_pcpi_valid, b_stall_req, b_m_result_valid, b_timeout_err;
    logic [31:0] b_pcpi_insn, b_pcpi_rs1, b_pcpi_rs2, b_m_result;
    logic [4:0]  b_m_rd_addr;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m_issue_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_instruction(ex_instruction),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_hold(ex_hold), .flush(flush),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
        .stall_req(stall_req), .m_result_valid(m_result_valid), .m_result(m_result),
        .m_rd_addr(m_rd_addr), .timeout_err(timeout_err)
    );

    m_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .ex_valid(b_ex_valid), .ex_instruction(ex_instruction),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_hold(ex_hold), .flush(flush),
        .pcpi_valid(b_pcpi_valid), .pcpi_insn(b_pcpi_insn), .pcpi_rs1(b_pcpi_rs1), .pcpi_rs2(b_pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
        .stall_req(b_stall_req), .m_result_valid(b_m_result_valid), .m_result(b_m_result),
        .m_rd_addr(b_m_rd_addr), .timeout_err(b_timeout_err)
    );

    typedef struct {
        logic        valid;
        logic [31:0] insn;
        logic        fl;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, mk(3'd0, 5'd5), 1'b0, 1'b1};
        vecs[1] = '{1'b1, mk(3'd1, 5'd5), 1'b0, 1'b1};
        vecs[2] = '{1'b1, mk(3'd2, 5'd5), 1'b0, 1'b1};
        vecs[3] = '{1'b1, mk(3'd5, 5'd5), 1'b0, 1'b1};
        vecs[4] = '{1'b1, mk(3'd7, 5'd0), 1'b0, 1'b1};
        vecs[5] = '{1'b1, {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011}, 1'b0, 1'b0};
        vecs[6] = '{1'b1, {7'b0100000, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0110011}, 1'b0, 1'b0};
        vecs[7] = '{1'b1, {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd5, 7'b0010011}, 1'b0, 1'b0};
        vecs[8] = '{1'b0, mk(3'd4, 5'd5), 1'b0, 1'b0};
        vecs[9] = '{1'b1, mk(3'd6, 5'd5), 1'b1, 1'b0};

        tick();
        tick();
        chk("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("rst_pcpi_insn", pcpi_insn, 32'd0);
        chk("rst_pcpi_rs1", pcpi_rs1, 32'd0);
        chk("rst_pcpi_rs2", pcpi_rs2, 32'd0);
        chk("rst_m_result", m_result, 32'd0);
        chk("rst_m_result_valid", {31'd0, m_result_valid}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        reset = 1'b0;
        tick();

        // decode table: combinational stall_req in IDLE, never clocked while issuing
        for (int i = 0; i < 10; i++) begin
            ex_valid = vecs[i].valid;
            ex_instruction = vecs[i].insn;
            flush = vecs[i].fl;
            #1;
            chk($sformatf("decode_stall[%0d]", i), {31'd0, stall_req}, {31'd0, vecs[i].exp_stall});
            ex_valid = 1'b0;
            flush = 1'b0;
            tick();
            chk($sformatf("decode_no_valid[%0d]", i), {31'd0, pcpi_valid}, 32'd0);
        end

        // MUL x5, 7*6, ready in third WAIT cycle
        ex_valid = 1'b1; ex_instruction = mk(3'd0, 5'd5); ex_rs1 = 32'd7; ex_rs2 = 32'd6;
        #1;
        chk("mul_detect_stall", {31'd0, stall_req}, 32'd1);
        chk("mul_detect_novalid", {31'd0, pcpi_valid}, 32'd0);
        tick();
        ex_rs1 = 32'd99;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("mul_valid_c%0d", c), {31'd0, pcpi_valid}, 32'd1);
            chk($sformatf("mul_insn_c%0d", c), pcpi_insn, mk(3'd0, 5'd5));
            chk($sformatf("mul_rs1_c%0d", c), pcpi_rs1, 32'd7);
            chk($sformatf("mul_rs2_c%0d", c), pcpi_rs2, 32'd6);
            chk($sformatf("mul_stall_c%0d", c), {31'd0, stall_req}, 32'd1);
            if (c == 3) begin
                pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd42;
            end
            tick();
        end
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("mul_res_valid", {31'd0, m_result_valid}, 32'd1);
        chk("mul_result", m_result, 32'd42);
        chk("mul_rd_addr", {27'd0, m_rd_addr}, 32'd5);
        chk("mul_done_stall", {31'd0, stall_req}, 32'd0);
        chk("mul_done_novalid", {31'd0, pcpi_valid}, 32'd0);
        ex_valid = 1'b0;
        tick();
        chk("mul_res_pulse", {31'd0, m_result_valid}, 32'd0);

        // DIVU 100/0, answer after 33 WAIT cycles
        ex_valid = 1'b1; ex_instruction = mk(3'd5, 5'd10); ex_rs1 = 32'd100; ex_rs2 = 32'd0;
        tick();
        pcpi_busy = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            chk($sformatf("divu_valid_c%0d", c), {31'd0, pcpi_valid}, 32'd1);
            if (c == 33) begin
                pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hFFFF_FFFF; pcpi_busy = 1'b0;
            end
            tick();
        end
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("divu_res_valid", {31'd0, m_result_valid}, 32'd1);
        chk("divu_result", m_result, 32'hFFFF_FFFF);
        chk("divu_no_timeout", {31'd0, timeout_err}, 32'd0);
        chk("divu_rd_addr", {27'd0, m_rd_addr}, 32'd10);
        ex_valid = 1'b0;
        tick();

        // silent responder: short-timeout instance abandons after 8, main after 64
        ex_valid = 1'b1; b_ex_valid = 1'b1; ex_instruction = mk(3'd0, 5'd3);
        ex_rs1 = 32'd1; ex_rs2 = 32'd2;
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("to8_valid_c%0d", c), {31'd0, b_pcpi_valid}, 32'd1);
            chk($sformatf("to8_noerr_c%0d", c), {31'd0, b_timeout_err}, 32'd0);
            tick();
        end
        chk("to8_err", {31'd0, b_timeout_err}, 32'd1);
        chk("to8_res_valid", {31'd0, b_m_result_valid}, 32'd1);
        chk("to8_result", b_m_result, 32'd0);
        chk("to8_valid_drop", {31'd0, b_pcpi_valid}, 32'd0);
        chk("to64_still_waiting", {31'd0, pcpi_valid}, 32'd1);
        chk("to64_no_early_err", {31'd0, timeout_err}, 32'd0);
        b_ex_valid = 1'b0;
        tick();
        chk("to8_err_pulse", {31'd0, b_timeout_err}, 32'd0);
        for (int c = 10; c <= 64; c++) begin
            chk($sformatf("to64_valid_c%0d", c), {31'd0, pcpi_valid}, 32'd1);
            tick();
        end
        chk("to64_err", {31'd0, timeout_err}, 32'd1);
        chk("to64_res_valid", {31'd0, m_result_valid}, 32'd1);
        chk("to64_result", m_result, 32'd0);
        ex_valid = 1'b0;
        tick();
        chk("to64_err_pulse", {31'd0, timeout_err}, 32'd0);
        chk("to64_res_pulse", {31'd0, m_result_valid}, 32'd0);

        // flush in 2nd WAIT cycle, unit busy 4 more cycles, MULHU waits behind it
        ex_valid = 1'b1; ex_instruction = mk(3'd4, 5'd7); ex_rs1 = 32'd50; ex_rs2 = 32'd7;
        tick();
        chk("fl_wait1", {31'd0, pcpi_valid}, 32'd1);
        pcpi_busy = 1'b1;
        tick();
        chk("fl_wait2", {31'd0, pcpi_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ex_instruction = mk(3'd3, 5'd8); ex_rs1 = 32'hFFFF_0000; ex_rs2 = 32'h0001_0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fl_drain_novalid[%0d]", i), {31'd0, pcpi_valid}, 32'd0);
            chk($sformatf("fl_drain_nores[%0d]", i), {31'd0, m_result_valid}, 32'd0);
            chk($sformatf("fl_drain_stall[%0d]", i), {31'd0, stall_req}, 32'd1);
            pcpi_ready = (i == 1);
            tick();
        end
        pcpi_ready = 1'b0; pcpi_busy = 1'b0;
        #1;
        chk("fl_idle_drain_stall", {31'd0, stall_req}, 32'd1);
        chk("fl_idle_drain_novalid", {31'd0, pcpi_valid}, 32'd0);
        chk("fl_ready_discarded", {31'd0, m_result_valid}, 32'd0);
        tick();
        chk("fl_idle_stall", {31'd0, stall_req}, 32'd1);
        chk("fl_idle_novalid", {31'd0, pcpi_valid}, 32'd0);
        tick();
        chk("mulhu_valid", {31'd0, pcpi_valid}, 32'd1);
        chk("mulhu_insn", pcpi_insn, mk(3'd3, 5'd8));
        chk("mulhu_rs1", pcpi_rs1, 32'hFFFF_0000);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0000_FFFF;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("mulhu_res_valid", {31'd0, m_result_valid}, 32'd1);
        chk("mulhu_result", m_result, 32'h0000_FFFF);
        chk("mulhu_rd_addr", {27'd0, m_rd_addr}, 32'd8);
        ex_valid = 1'b0;
        tick();

        // flush and ready together in WAIT: flush wins
        ex_valid = 1'b1; ex_instruction = mk(3'd0, 5'd11);
        tick();
        flush = 1'b1; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd5;
        tick();
        flush = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; ex_valid = 1'b0;
        chk("flrdy_nores", {31'd0, m_result_valid}, 32'd0);
        chk("flrdy_novalid", {31'd0, pcpi_valid}, 32'd0);
        tick();
        chk("flrdy_nores2", {31'd0, m_result_valid}, 32'd0);
        chk("flrdy_result_kept", m_result, 32'h0000_FFFF);
        tick();

        // ex_hold for 3 cycles in DONE
        ex_valid = 1'b1; ex_instruction = mk(3'd0, 5'd9);
        tick();
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h1234_5678;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ex_hold = (c < 3);
            #1;
            chk($sformatf("hold_res_valid[%0d]", c), {31'd0, m_result_valid}, 32'd1);
            chk($sformatf("hold_result[%0d]", c), m_result, 32'h1234_5678);
            chk($sformatf("hold_novalid[%0d]", c), {31'd0, pcpi_valid}, 32'd0);
            chk($sformatf("hold_nostall[%0d]", c), {31'd0, stall_req}, 32'd0);
            if (c == 3) ex_valid = 1'b0;
            tick();
        end
        chk("hold_release", {31'd0, m_result_valid}, 32'd0);
        chk("hold_no_reissue", {31'd0, pcpi_valid}, 32'd0);

        // reset in 5th WAIT cycle of a REM
        ex_valid = 1'b1; ex_instruction = mk(3'd6, 5'd12); ex_rs1 = 32'd17; ex_rs2 = 32'd5;
        tick();
        pcpi_busy = 1'b1;
        for (int c = 1; c < 5; c++) tick();
        chk("rem_wait5_valid", {31'd0, pcpi_valid}, 32'd1);
        reset = 1'b1;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, pcpi_valid}, 32'd0);
        chk("rst_mid_insn", pcpi_insn, 32'd0);
        chk("rst_mid_rs1", pcpi_rs1, 32'd0);
        chk("rst_mid_rs2", pcpi_rs2, 32'd0);
        chk("rst_mid_result", m_result, 32'd0);
        chk("rst_mid_res_valid", {31'd0, m_result_valid}, 32'd0);
        chk("rst_mid_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall_req}, 32'd0);
        reset = 1'b0; pcpi_busy = 1'b0;
        tick();
        ex_valid = 1'b1; ex_instruction = mk(3'd0, 5'd4); ex_rs1 = 32'd3; ex_rs2 = 32'd3;
        tick();
        chk("mul33_valid", {31'd0, pcpi_valid}, 32'd1);
        chk("mul33_rs1", pcpi_rs1, 32'd3);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd9;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; ex_valid = 1'b0;
        chk("mul33_res_valid", {31'd0, m_result_valid}, 32'd1);
        chk("mul33_result", m_result, 32'd9);
        chk("mul33_rd_addr", {27'd0, m_rd_addr}, 32'd4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
